// File: rtl/osd_pkg.sv
// Shared definitions for the OSD string renderer.
//   - screen, atlas and descriptor size constants
//   - FSM state encoding
//   - overlay pixel record {x, y, color, on}
//   - on_screen(): visibility test on wide screen coordinates
package osd_pkg;

  localparam int STRING_LENGTH = 60;
  localparam int CHAR_ENCODING = 12;
  localparam int DATA_WIDTH    = 24;
  localparam int PAGES         = 2;
  localparam int PNG_W         = 64;
  localparam int PNG_H         = 64;
  localparam int CHAR_SPACING  = 1;
  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;

  localparam int X_W    = $clog2(SCREEN_W);
  localparam int Y_W    = $clog2(SCREEN_H);
  localparam int CC_W   = $clog2(STRING_LENGTH);
  localparam int ADDR_W = $clog2(PAGES * PNG_W * PNG_H);

  // Wide coordinate width: cursor (X_W+1 bits) plus a full descriptor-sized
  // offset cannot overflow this.
  localparam int POS_W = CHAR_ENCODING + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DRAW,
    NEXT,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [DATA_WIDTH-1:0] color;
    logic                  on;
  } pix_t;

  function automatic logic on_screen(input logic [POS_W-1:0] x,
                                     input logic [POS_W-1:0] y);
    return (x < POS_W'(SCREEN_W)) && (y < POS_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/osd_glyph_walker.sv
// Row/column walker over one glyph in the font atlas.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture a new glyph (base address, width, length)
//   base          glyph top-left atlas address
//   width, length glyph size in columns / rows
//   step          one atlas read was issued this cycle; advance to next pixel
//   row, col      position of the pixel whose address is on addr
//   addr          atlas read address (held when step is low)
//   more          at least one pixel of the glyph still to be issued
module osd_glyph_walker
  import osd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        base,
  input  logic [CHAR_ENCODING-1:0] width,
  input  logic [CHAR_ENCODING-1:0] length,
  input  logic                     step,
  output logic [CHAR_ENCODING-1:0] row,
  output logic [CHAR_ENCODING-1:0] col,
  output logic [ADDR_W-1:0]        addr,
  output logic                     more
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(PNG_W);

  logic [CHAR_ENCODING-1:0] w_q;
  logic [CHAR_ENCODING-1:0] l_q;
  logic [ADDR_W-1:0]        row_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q      <= '0;
      l_q      <= '0;
      row      <= '0;
      col      <= '0;
      addr     <= '0;
      row_base <= '0;
      more     <= 1'b0;
    end else if (load) begin
      w_q      <= width;
      l_q      <= length;
      row      <= '0;
      col      <= '0;
      addr     <= base;
      row_base <= base;
      more     <= (width != '0) && (length != '0);
    end else if (step && more) begin
      if (col == w_q - 1'b1) begin
        col <= '0;
        if (row == l_q - 1'b1) begin
          more <= 1'b0;
        end else begin
          row      <= row + 1'b1;
          row_base <= row_base + ROW_STRIDE;
          addr     <= row_base + ROW_STRIDE;
        end
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/osd_string_renderer.sv
// OSD string renderer: steps through the characters of a string, fetches
// each glyph descriptor, walks the glyph in the pattern ROM and emits one
// overlay pixel per cycle over a valid/ready handshake.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, str_len           render request (ignored while busy), char count
//   origin_x, origin_y       top-left of first glyph, sampled on start
//   char_count, enable_start descriptor ROM index and enable
//   char_width, char_length, pattern_addr, char_color   descriptor fields
//   pat_rd_addr, pat_rd_data pattern ROM port (synchronous, 1-cycle latency)
//   pix_valid, pix_ready     pixel handshake
//   pix_x, pix_y, pix_color, pix_on   pixel payload
//   busy, done               status; done pulses once per string
// Build option: OSD_TRANSPARENT_SKIP_EN drops pattern-0 pixels instead of
// emitting them with pix_on = 0.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | char_count on descriptor ROM address
// LATCH | descriptor valid; capture it and load the walker
// DRAW  | issue atlas reads and stream pixels
// NEXT  | advance cursor and character index
// FLUSH | wait for the final pixel to be accepted
module osd_string_renderer
  import osd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CC_W-1:0]          str_len,
  input  logic [X_W-1:0]           origin_x,
  input  logic [Y_W-1:0]           origin_y,
  output logic [CC_W-1:0]          char_count,
  output logic                     enable_start,
  input  logic [CHAR_ENCODING-1:0] char_width,
  input  logic [CHAR_ENCODING-1:0] char_length,
  input  logic [ADDR_W-1:0]        pattern_addr,
  input  logic [DATA_WIDTH-1:0]    char_color,
  output logic [ADDR_W-1:0]        pat_rd_addr,
  input  logic                     pat_rd_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [X_W-1:0]           pix_x,
  output logic [Y_W-1:0]           pix_y,
  output logic [DATA_WIDTH-1:0]    pix_color,
  output logic                     pix_on,
  output logic                     busy,
  output logic                     done
);

  localparam logic [POS_W-1:0] CUR_MAX = POS_W'((1 << (X_W + 1)) - 1);

  state_t                   state;
  logic [CC_W-1:0]          str_len_q;
  logic [Y_W-1:0]           oy_q;
  logic [X_W:0]             cursor;
  logic [CHAR_ENCODING-1:0] glyph_w;
  logic [DATA_WIDTH-1:0]    color_q;
  pix_t                     pix_q;

  // Single in-flight read slot. s1_live: data is on pat_rd_data this cycle;
  // otherwise it was parked in s1_bit because the output was stalled.
  logic           s1_vld;
  logic           s1_live;
  logic           s1_bit;
  logic           s1_clip;
  logic [X_W-1:0] s1_x;
  logic [Y_W-1:0] s1_y;

  logic [CHAR_ENCODING-1:0] w_row;
  logic [CHAR_ENCODING-1:0] w_col;
  logic                     w_more;

  logic             load_en;
  logic             bit_now;
  logic             drop;
  logic             consume;
  logic             step;
  logic             glyph_end;
  logic             last_char;
  logic [POS_W-1:0] nx;
  logic [POS_W-1:0] ny;
  logic [POS_W-1:0] adv;

  assign load_en = !pix_valid || pix_ready;
  assign bit_now = s1_live ? pat_rd_data : s1_bit;

`ifdef OSD_TRANSPARENT_SKIP_EN
  assign drop = s1_clip || !bit_now;
`else
  assign drop = s1_clip;
`endif

  // Dropped pixels never touch the output register, so they retire even
  // while the output is stalled.
  assign consume   = s1_vld && (load_en || drop);
  assign step      = (state == DRAW) && w_more && (!s1_vld || consume);
  assign glyph_end = (state == DRAW) && !w_more && (!s1_vld || consume);
  assign last_char = (char_count + 1'b1) == str_len_q;

  assign nx  = POS_W'(cursor) + POS_W'(w_col);
  assign ny  = POS_W'(oy_q) + POS_W'(w_row);
  assign adv = POS_W'(cursor) + POS_W'(glyph_w) + POS_W'(CHAR_SPACING);

  osd_glyph_walker u_walker (
    .clk    (clk),
    .rst    (rst),
    .load   (state == LATCH),
    .base   (pattern_addr),
    .width  (char_width),
    .length (char_length),
    .step   (step),
    .row    (w_row),
    .col    (w_col),
    .addr   (pat_rd_addr),
    .more   (w_more)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_live <= 1'b0;
      s1_bit  <= 1'b0;
      s1_clip <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else if (step) begin
      s1_vld  <= 1'b1;
      s1_live <= 1'b1;
      s1_clip <= !on_screen(nx, ny);
      s1_x    <= nx[X_W-1:0];
      s1_y    <= ny[Y_W-1:0];
    end else if (consume) begin
      s1_vld  <= 1'b0;
      s1_live <= 1'b0;
    end else if (s1_live) begin
      s1_live <= 1'b0;
      s1_bit  <= pat_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_q     <= '0;
    end else if (load_en) begin
      pix_valid <= consume && !drop;
      if (consume && !drop) begin
        pix_q.x     <= s1_x;
        pix_q.y     <= s1_y;
        pix_q.color <= color_q;
        pix_q.on    <= bit_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      str_len_q  <= '0;
      oy_q       <= '0;
      cursor     <= '0;
      glyph_w    <= '0;
      color_q    <= '0;
      char_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            str_len_q  <= str_len;
            oy_q       <= origin_y;
            cursor     <= {1'b0, origin_x};
            char_count <= '0;
            state      <= (str_len == '0) ? FLUSH : FETCH;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          glyph_w <= char_width;
          color_q <= char_color;
          state   <= (char_width == '0 || char_length == '0) ? NEXT : DRAW;
        end
        DRAW: begin
          if (glyph_end) state <= NEXT;
        end
        NEXT: begin
          // Saturate: an off-screen cursor only has to stay off-screen.
          cursor <= (adv > CUR_MAX) ? CUR_MAX[X_W:0] : adv[X_W:0];
          if (last_char) begin
            if (load_en) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end else begin
            char_count <= char_count + 1'b1;
            state      <= FETCH;
          end
        end
        FLUSH: begin
          if (load_en) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign enable_start = (state == FETCH) || (state == LATCH) || (state == DRAW);
  assign busy         = (state != IDLE);
  assign pix_x        = pix_q.x;
  assign pix_y        = pix_q.y;
  assign pix_color    = pix_q.color;
  assign pix_on       = pix_q.on;

endmodule

// File: tb/tb_osd_string_renderer.sv
module tb_osd_string_renderer;
  import osd_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [CC_W-1:0]          str_len;
  logic [X_W-1:0]           origin_x;
  logic [Y_W-1:0]           origin_y;
  logic [CC_W-1:0]          char_count;
  logic                     enable_start;
  logic [CHAR_ENCODING-1:0] char_width;
  logic [CHAR_ENCODING-1:0] char_length;
  logic [ADDR_W-1:0]        pattern_addr;
  logic [DATA_WIDTH-1:0]    char_color;
  logic [ADDR_W-1:0]        pat_rd_addr;
  logic                     pat_rd_data;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [X_W-1:0]           pix_x;
  logic [Y_W-1:0]           pix_y;
  logic [DATA_WIDTH-1:0]    pix_color;
  logic                     pix_on;
  logic                     busy;
  logic                     done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  osd_string_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .str_len      (str_len),
    .origin_x     (origin_x),
    .origin_y     (origin_y),
    .char_count   (char_count),
    .enable_start (enable_start),
    .char_width   (char_width),
    .char_length  (char_length),
    .pattern_addr (pattern_addr),
    .char_color   (char_color),
    .pat_rd_addr  (pat_rd_addr),
    .pat_rd_data  (pat_rd_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_color    (pix_color),
    .pix_on       (pix_on),
    .busy         (busy),
    .done         (done)
  );

  // Atlas content: a fixed function of the address so the bench can predict
  // every pattern bit.
  function automatic logic pat_bit(input logic [ADDR_W-1:0] a);
    return ~a[0] ^ a[6] ^ (a[1] & a[2]) ^ a[4] ^ a[9];
  endfunction

  logic [CHAR_ENCODING-1:0] dw [0:63];
  logic [CHAR_ENCODING-1:0] dl [0:63];
  logic [ADDR_W-1:0]        db [0:63];
  logic [DATA_WIDTH-1:0]    dc [0:63];

  always @(posedge clk) begin
    char_width   <= dw[char_count];
    char_length  <= dl[char_count];
    pattern_addr <= db[char_count];
    char_color   <= dc[char_count];
    pat_rd_data  <= pat_bit(pat_rd_addr);
  end

  typedef struct packed {
    logic [CC_W-1:0]       len;
    logic [X_W-1:0]        ox;
    logic [Y_W-1:0]        oy;
    logic                  rnd;
    logic                  poke;
    logic                  chk_lat;
    logic [2:0][11:0]      w;
    logic [2:0][11:0]      l;
    logic [2:0][ADDR_W-1:0] base;
    int                    exp_n;
    int                    exp_fx;
    int                    exp_lx;
  } vec_t;

  vec_t vecs [0:8];

  function automatic vec_t mk(input int len, input int ox, input int oy,
                              input bit rnd, input bit poke, input bit chk_lat,
                              input int w0, input int l0, input int b0,
                              input int w1, input int l1, input int b1,
                              input int w2, input int l2, input int b2,
                              input int n, input int fx, input int lx);
    vec_t v;
    v.len = CC_W'(len); v.ox = X_W'(ox); v.oy = Y_W'(oy);
    v.rnd = rnd; v.poke = poke; v.chk_lat = chk_lat;
    v.w[0] = 12'(w0); v.l[0] = 12'(l0); v.base[0] = ADDR_W'(b0);
    v.w[1] = 12'(w1); v.l[1] = 12'(l1); v.base[1] = ADDR_W'(b1);
    v.w[2] = 12'(w2); v.l[2] = 12'(l2); v.base[2] = ADDR_W'(b2);
    v.exp_n = n; v.exp_fx = fx; v.exp_lx = lx;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_desc(input int vi);
    for (int g = 0; g < 3; g++) begin
      dw[g] = vecs[vi].w[g];
      dl[g] = vecs[vi].l[g];
      db[g] = vecs[vi].base[g];
      dc[g] = 24'hA00000 + DATA_WIDTH'(vi * 16 + g);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    pix_t exp_q[$];
    pix_t got_q[$];
    pix_t p;
    int cur, x, y, cyc, last_xfer, done_cyc, fx, lx;
    bit seen_done;
    logic [ADDR_W-1:0] a;
    logic b;
    logic [3:0] ons;
    v = vecs[vi];
    set_desc(vi);

    // reference model
    cur = int'(v.ox);
    for (int g = 0; g < int'(v.len); g++) begin
      for (int r = 0; r < int'(v.l[g]); r++) begin
        for (int c = 0; c < int'(v.w[g]); c++) begin
          x = cur + c;
          y = int'(v.oy) + r;
          a = ADDR_W'(int'(v.base[g]) + r * PNG_W + c);
          b = pat_bit(a);
          if (x < SCREEN_W && y < SCREEN_H) begin
`ifdef OSD_TRANSPARENT_SKIP_EN
            if (b) begin
              p.x = X_W'(x); p.y = Y_W'(y); p.color = dc[g]; p.on = 1'b1;
              exp_q.push_back(p);
            end
`else
            p.x = X_W'(x); p.y = Y_W'(y); p.color = dc[g]; p.on = b;
            exp_q.push_back(p);
`endif
          end
        end
      end
      cur = cur + int'(v.w[g]) + CHAR_SPACING;
    end

    @(negedge clk);
    str_len = v.len; origin_x = v.ox; origin_y = v.oy; start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; str_len = '0; origin_x = '0; origin_y = '0;
    cyc = 0; seen_done = 0; last_xfer = -100; done_cyc = -1;
    while (!seen_done && cyc < 2000) begin
      start = (v.poke && cyc == 4) ? 1'b1 : 1'b0;
      if (v.poke && cyc == 4) str_len = CC_W'(1);
      pix_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pix_valid && pix_ready) begin
        p.x = pix_x; p.y = pix_y; p.color = pix_color; p.on = pix_on;
        got_q.push_back(p);
        last_xfer = cyc;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
      end
    end
    pix_ready = 1'b1;

    check($sformatf("v%0d_done_seen", vi), longint'(seen_done), 1);
    check($sformatf("v%0d_busy_at_done", vi), longint'(busy), 0);
    if (v.chk_lat) check($sformatf("v%0d_done_latency", vi), done_cyc - last_xfer, 1);
    check($sformatf("v%0d_count_model", vi), got_q.size(), exp_q.size());
    fx = (got_q.size() > 0) ? int'(got_q[0].x) : -1;
    lx = (got_q.size() > 0) ? int'(got_q[got_q.size()-1].x) : -1;
`ifdef OSD_TRANSPARENT_SKIP_EN
    if (vi == 5) begin
      check("v5_count", got_q.size(), 2);
      check("v5_first_x", fx, 0);
      check("v5_last_x", lx, 2);
    end
`else
    check($sformatf("v%0d_count", vi), got_q.size(), v.exp_n);
    check($sformatf("v%0d_first_x", vi), fx, v.exp_fx);
    check($sformatf("v%0d_last_x", vi), lx, v.exp_lx);
    if (vi == 5) begin
      ons = '0;
      for (int i = 0; i < 4 && i < got_q.size(); i++) ons[3-i] = got_q[i].on;
      check("v5_on_bits", ons, 4'b1010);
    end
`endif
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("v%0d_pix%0d", vi, i), longint'(got_q[i]), longint'(exp_q[i]));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; str_len = '0; origin_x = '0; origin_y = '0;
    pix_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dw[i] = '0; dl[i] = '0; db[i] = '0; dc[i] = '0;
    end
    //            len ox  oy  rnd poke lat  w0 l0 b0   w1 l1 b1   w2 l2 b2   n  fx  lx
    vecs[0] = mk(1, 10, 20, 0, 0, 1,   3, 2, 130, 0, 0, 0,   0, 0, 0,   6, 10, 12);
    vecs[1] = mk(2, 10, 20, 0, 0, 1,   3, 2, 130, 4, 1, 200, 0, 0, 0,   10, 10, 17);
    vecs[2] = mk(1, 10, 20, 1, 0, 1,   3, 2, 130, 0, 0, 0,   0, 0, 0,   6, 10, 12);
    vecs[3] = mk(3, 100, 50, 0, 0, 1,  2, 1, 0,   0, 5, 300, 2, 1, 10,  4, 100, 105);
    vecs[4] = mk(1, 638, 10, 0, 0, 0,  4, 2, 400, 0, 0, 0,   0, 0, 0,   4, 638, 639);
    vecs[5] = mk(1, 0, 0, 0, 0, 1,     4, 1, 0,   0, 0, 0,   0, 0, 0,   4, 0, 3);
    vecs[6] = mk(2, 5, 5, 0, 0, 0,     2, 1, 20,  3, 0, 40,  0, 0, 0,   2, 5, 6);
    vecs[7] = mk(1, 300, 479, 0, 1, 0, 2, 2, 66,  0, 0, 0,   0, 0, 0,   2, 300, 301);
    vecs[8] = mk(2, 10, 20, 1, 1, 1,   3, 2, 130, 4, 1, 200, 0, 0, 0,   10, 10, 17);

    repeat (3) @(negedge clk);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_char_count", char_count, 0);
    check("rst_pat_rd_addr", pat_rd_addr, 0);
    check("rst_enable_start", enable_start, 0);
    check("rst_pix_x", pix_x, 0);
    rst = 1'b0;
    @(negedge clk);

    // empty string: one busy cycle, then a lone done pulse
    str_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", busy, 1);
    check("len0_done_early", done, 0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_busy_off", busy, 0);
    check("len0_no_pix", pix_valid, 0);
    @(negedge clk);
    check("len0_done_pulse", done, 0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // stall hold and asynchronous reset in the middle of a glyph
    set_desc(0);
    @(negedge clk);
    str_len = CC_W'(1); origin_x = X_W'(10); origin_y = Y_W'(20);
    pix_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; str_len = '0;
    check("mid_fetch_enable", enable_start, 1);
    check("mid_fetch_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("stall_valid", pix_valid, 1);
    check("stall_x", pix_x, 10);
    check("stall_on", pix_on, pat_bit(ADDR_W'(130)));
    check("stall_addr", pat_rd_addr, 132);
    repeat (2) @(negedge clk);
    check("stall_hold_addr", pat_rd_addr, 132);
    check("stall_hold_x", pix_x, 10);
    #2 rst = 1'b1;
    #1;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", pat_rd_addr, 0);
    check("arst_enable", enable_start, 0);
    check("arst_pix_x", pix_x, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
